// File: rtl/disp_arbiter_pkg.sv
// disp_arbiter_pkg
//   Shared definitions for the string dispatch arbiter:
//   - default sizes for the number of requesters and the string length
//   - the byte constants the FSM emits or detects (CR, LF, NUL)
//   - the FSM state enum (the CRLF state exists only when DISP_CRLF_EN is defined)
//   - a width helper that keeps counters at least one bit wide
package disp_arbiter_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int STR_BYTES_DEF = 8;

   localparam logic [7:0] CR_BYTE  = 8'h0D;
   localparam logic [7:0] LF_BYTE  = 8'h0A;
   localparam logic [7:0] NUL_BYTE = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
`ifdef DISP_CRLF_EN
      ST_CRLF = 2'd2,
`endif
      ST_DONE = 2'd3
   } disp_state_e;

   // clog2 that never returns zero, so a one-entry configuration still has a 1-bit field
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/disp_arbiter_rr.sv
// rr_arbiter
//   Purely combinational round-robin picker. Searches the request vector upward
//   from the pointer position, wrapping at N, and returns the first requester found
//   as a one-hot vector (all zeros when nothing is requesting).
//   Ports:
//     req_i  [N-1:0]  request bits
//     ptr_i  [PW-1:0] index where the search starts (always < N)
//     gnt_o  [N-1:0]  one-hot winner
module rr_arbiter
   import disp_arbiter_pkg::*;
#(
   parameter int N  = NUM_REQ_DEF,
   parameter int PW = cw(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic found;
   int   idx;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter
//   Round-robin arbiter that grants one requester at a time and streams that
//   requester's NUL-terminated string (snapshotted at grant) to a byte transmitter.
//   Optional feature: define DISP_CRLF_EN to append CR LF after every string.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     req   [NUM_REQ]   level requests
//     str   [NUM_REQ*STR_BYTES*8] requester i string in slice i, byte 0 lowest
//     gnt   [NUM_REQ]   one-hot grant held for the whole transfer
//     done  [NUM_REQ]   one-cycle completion pulse to the granted requester
//     txValid/txData/txRdy  byte handshake to the transmitter
//     busy              high whenever the FSM is not idle
//     dbg_state         current FSM state
//   Handshake: a byte moves on every rising edge where txValid and txRdy are both
//   high; txValid/txData never change while txValid is high and txRdy is low.
module disp_arbiter
   import disp_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int STR_BYTES = STR_BYTES_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*STR_BYTES*8-1:0] str,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             done,
   output logic                           txValid,
   output logic [7:0]                     txData,
   input  logic                           txRdy,
   output logic                           busy,
   output disp_state_e                    dbg_state
);

   localparam int             PW      = cw(NUM_REQ);
   localparam int             KW      = cw(STR_BYTES);
   localparam int             SLICE_W = STR_BYTES * 8;
   localparam logic [KW-1:0]  K_LAST  = KW'(STR_BYTES - 1);

   disp_state_e        state_q;
   logic [NUM_REQ-1:0] gnt_q, done_q;
   logic               tx_valid_q;
   logic [7:0]         tx_data_q;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [KW-1:0]      k_q, k_d;
   logic [7:0]         snap_q [STR_BYTES];

   logic [NUM_REQ-1:0] win;
   logic [PW-1:0]      win_idx;
   logic [7:0]         win_byte0;
   logic [7:0]         nxt_byte;
   logic               last_xfer;

   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (win)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) win_idx = PW'(i);
      end
   end

   assign ptr_d     = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   assign win_byte0 = str[int'(win_idx) * SLICE_W +: 8];

   // k_d is only used when k_q is not the last index, so the wrap never reaches the outputs
   assign k_d       = (k_q == K_LAST) ? '0 : k_q + 1'b1;
   assign nxt_byte  = snap_q[k_d];
   assign last_xfer = (k_q == K_LAST) || (nxt_byte == NUL_BYTE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         done_q     <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= NUL_BYTE;
         ptr_q      <= '0;
         k_q        <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  state_q    <= ST_SEND;
                  gnt_q      <= win;
                  ptr_q      <= ptr_d;
                  k_q        <= '0;
                  for (int b = 0; b < STR_BYTES; b++) begin
                     snap_q[b] <= str[int'(win_idx) * SLICE_W + b * 8 +: 8];
                  end
                  // A NUL first byte means an empty string: sit in SEND one cycle without valid
                  tx_data_q  <= win_byte0;
                  tx_valid_q <= (win_byte0 != NUL_BYTE);
               end
            end

            ST_SEND: begin
               if (!tx_valid_q || (txRdy && last_xfer)) begin
                  k_q <= '0;
`ifdef DISP_CRLF_EN
                  state_q    <= ST_CRLF;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= CR_BYTE;
`else
                  state_q    <= ST_DONE;
                  tx_valid_q <= 1'b0;
                  tx_data_q  <= NUL_BYTE;
                  done_q     <= gnt_q;
`endif
               end else if (txRdy) begin
                  k_q       <= k_d;
                  tx_data_q <= nxt_byte;
               end
            end

`ifdef DISP_CRLF_EN
            ST_CRLF: begin
               if (txRdy) begin
                  if (tx_data_q == CR_BYTE) begin
                     tx_data_q <= LF_BYTE;
                  end else begin
                     state_q    <= ST_DONE;
                     tx_valid_q <= 1'b0;
                     tx_data_q  <= NUL_BYTE;
                     done_q     <= gnt_q;
                  end
               end
            end
`endif

            ST_DONE: begin
               state_q <= ST_IDLE;
               gnt_q   <= '0;
               done_q  <= '0;
            end

            default: begin
               state_q    <= ST_IDLE;
               gnt_q      <= '0;
               done_q     <= '0;
               tx_valid_q <= 1'b0;
               tx_data_q  <= NUL_BYTE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign txValid   = tx_valid_q;
   assign txData    = tx_data_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter STR_BYTES, default 8, giving the string length in bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, NUM_REQ bits: level request, one bit per requester.
REQ-006 The block SHALL have port str, input, NUM_REQ*STR_BYTES*8 bits: requester i string at slice i; byte 0 in its low 8 bits.
REQ-007 The block SHALL have port gnt, output, NUM_REQ bits: one-hot grant, held for the whole transfer.
REQ-008 The block SHALL have port done, output, NUM_REQ bits: one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port txValid, output, 1 bit: byte valid to the transmitter.
REQ-010 The block SHALL have port txData, output, 8 bits: byte to the transmitter.
REQ-011 The block SHALL have port txRdy, input, 1 bit: transmitter accepts; a byte transfers on any cycle with txValid and txRdy both high.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, CRLF (macro builds only) and DONE.
REQ-014 In IDLE with any req bit high at cycle t, the block SHALL, at t+1, assert the round-robin winner's gnt bit, snapshot its string, and enter SEND.
REQ-015 Round-robin SHALL search upward (with wrap) from pointer ptr; on grant, ptr SHALL become winner+1 mod NUM_REQ; ptr resets to 0.
REQ-016 In SEND, txValid SHALL be high and txData SHALL be snapshot byte k, with k starting at 0.
REQ-017 txData and txValid SHALL be held stable while txRdy is low.
REQ-018 On each transfer, k SHALL increment and the next byte SHALL be presented the following cycle, with no bubble.
REQ-019 A snapshot byte equal to 8'h00 SHALL terminate the string: it is not sent, and no later bytes are sent.
REQ-020 If byte 0 is 8'h00 (zero-length string), the block SHALL go directly to CRLF or DONE without asserting txValid.
REQ-021 The block SHALL leave SEND after byte STR_BYTES-1 transfers or on a terminator.
REQ-022 In DONE, for exactly one cycle: done[i] SHALL be high and gnt[i] SHALL be high. Next cycle: gnt SHALL clear and the FSM SHALL return to IDLE.
REQ-023 A new arbitration SHALL be possible on the cycle after the return to IDLE.
REQ-024 req changes while granted SHALL be ignored; the granted string SHALL always complete from the snapshot, even if str changes.
REQ-025 Byte counter k SHALL be clog2(STR_BYTES) bits wide, and its wrap SHALL never be observable.
REQ-026 At most one gnt bit and at most one done bit SHALL be high on any cycle.

Reset
REQ-027 On rst, at the next edge, the block SHALL go to IDLE and force gnt=0, done=0, txValid=0, txData=8'h00, busy=0, ptr=0, k=0.
REQ-028 Reset asserted mid-transfer SHALL abandon the string, with no done pulse.
REQ-029 rst SHALL override all other inputs.

Configuration
REQ-030 With macro DISP_CRLF_EN defined: after SEND (including zero-length strings), the CRLF state SHALL send 8'h0D then 8'h0A under the same txRdy handshake, then enter DONE.
REQ-031 Without DISP_CRLF_EN: the CRLF state and its logic SHALL be absent, and SEND SHALL go directly to DONE.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the CR/LF/NUL byte constants and the defaults for NUM_REQ and STR_BYTES.
REQ-033 One sub-module, rr_arbiter (request vector plus pointer in, one-hot winner out), SHALL be instantiated; it SHALL be purely combinational.

Verification
REQ-034 Single request: req=4'b0001, str0="HELLO!!!", txRdy=1 -> gnt[0] at t+1; bytes 48 45 4C 4C 4F 21 21 21 on 8 consecutive cycles; done[0] pulse; busy=0 afterwards.
REQ-035 Back-pressure: txRdy toggles 1,0,0,1,... -> txData held while txRdy=0; no byte lost or duplicated.
REQ-036 Contention: req=4'b1111 held, ptr=0 -> grants in order 0,1,2,3,0; exactly one gnt at a time.
REQ-037 Terminator: str1 byte 3 = 8'h00 -> exactly 3 bytes sent; done[1] pulses. str2 all zero -> no txValid; done[2] pulses 2 cycles after request.
REQ-038 Reset mid-string: rst asserted after the 4th byte -> next cycle txValid=0 and gnt=0; no done pulse; the next request starts at byte 0.
REQ-039 DISP_CRLF_EN build: str0="AB" followed by NUL -> bytes 41 42 0D 0A, then done[0].
